// File: rtl/score_pkg.sv
// Shared BCD types and helpers for the score keeper: digit type, the largest
// digit code, and a packed-BCD magnitude compare used for the high score.
package score_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   MAX_DIGITS = 8;
    localparam int   MAX_WIDTH  = 4 * MAX_DIGITS;

    typedef logic [MAX_WIDTH-1:0] bcd_vec_t;

    // Walks from the most significant digit; the first differing digit decides.
    function automatic logic bcd_gt(input bcd_vec_t a, input bcd_vec_t b);
        logic decided;
        logic result;
        decided = 1'b0;
        result  = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                result  = (a[4*i +: 4] > b[4*i +: 4]);
            end
        end
        return result;
    endfunction

    function automatic bcd_t bcd_next(input bcd_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/score_bcd_counter_digit.sv
// One decimal digit of the score: clears on clr, steps on inc, wraps 9 -> 0
// and raises carry combinationally so the next digit steps in the same cycle.
module bcd_digit
    import score_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= bcd_next(r_q);
        end
    end

    assign q     = r_q;
    assign carry = inc & (r_q == BCD_MAX);

endmodule

// File: rtl/score_bcd_counter.sv
// Score keeper: one point per rising edge of pass_lvl, packed BCD score that
// saturates at all nines, and a registered best-score tracker with record flag.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int DIGITS = 3
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                pass_lvl,
    input  logic                new_game,
    output logic [4*DIGITS-1:0] score,
    output logic [4*DIGITS-1:0] high,
    output logic                new_high,
    output logic                saturated
);

    localparam int              W         = 4 * DIGITS;
    localparam logic [W-1:0]    ALL_NINES = {DIGITS{BCD_MAX}};

    logic           r_passPrev;
    logic           w_point;
    logic           w_sat;
    logic           w_inc;
    logic [DIGITS:0] w_carry;
    logic           w_unusedTopCarry;
    logic [W-1:0]   w_score;
    logic [W-1:0]   r_high;
    logic           r_newHigh;
    bcd_vec_t       w_scoreExt;
    bcd_vec_t       w_highExt;
    logic           w_beats;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_passPrev <= 1'b0;
        end else begin
            r_passPrev <= pass_lvl;
        end
    end

    // A new game outranks a point arriving in the same cycle.
    assign w_point    = pass_lvl & ~r_passPrev;
    assign w_sat      = (w_score == ALL_NINES);
    assign w_inc      = w_point & ~w_sat & ~new_game;
    assign w_carry[0] = w_inc;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (new_game),
            .inc   (w_carry[d]),
            .q     (w_score[4*d +: 4]),
            .carry (w_carry[d+1])
        );
    end

    // The saturation gate means the top digit can never carry out.
    assign w_unusedTopCarry = w_carry[DIGITS];

    always_comb begin
        w_scoreExt        = '0;
        w_highExt         = '0;
        w_scoreExt[W-1:0] = w_score;
        w_highExt[W-1:0]  = r_high;
    end

    assign w_beats = bcd_gt(w_scoreExt, w_highExt);

    // The record is still captured on a new_game cycle; only the flag is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high    <= '0;
            r_newHigh <= 1'b0;
        end else begin
            if (w_beats) begin
                r_high <= w_score;
            end
            if (new_game) begin
                r_newHigh <= 1'b0;
            end else if (w_beats) begin
                r_newHigh <= 1'b1;
            end
        end
    end

    assign score     = w_score;
    assign high      = r_high;
    assign new_high  = r_newHigh;
    assign saturated = w_sat;

endmodule
